bp_be_prefetch_issuer: RTL and testbench

Consumes stride-discovery events (start/confirm, base address, stride) from the BE stride detector and turns them into a paced stream of D$ prefetch requests. Generates base+k*stride for k=1..N, bounded to the base's 4 KiB page. Drops candidates whose cache line was recently issued. Presents requests on a valid/ready interface to the dcache prefetch port.

---
 rtl/bp_be_prefetch_issuer.sv | 171 +++++++++++++++++
 tb/tb_bp_be_prefetch_issuer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_prefetch_issuer.sv
// Turns stride-discovery events into a paced, page-bounded stream of D$ prefetch requests,
// suppressing candidates whose cache line was recently issued.
module bp_be_prefetch_issuer #(
    parameter int unsigned vaddr_width_p        = 39,
    parameter int unsigned stride_width_p       = 8,
    parameter int unsigned degree_p             = 4,
    parameter int unsigned filter_els_p         = 8,
    parameter int unsigned block_offset_width_p = 6,
    parameter int unsigned page_offset_width_p  = 12
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_discovery_i,
    input  logic                      confirm_discovery_i,
    input  logic [vaddr_width_p-1:0]  addr_i,
    input  logic [stride_width_p-1:0] stride_i,
    output logic                      pf_v_o,
    output logic [vaddr_width_p-1:0]  pf_addr_o,
    input  logic                      pf_ready_and_i,
    output logic                      busy_o
);

    localparam int unsigned LineW = vaddr_width_p - block_offset_width_p;
    localparam int unsigned PageW = vaddr_width_p - page_offset_width_p;
    localparam int unsigned CntW  = $clog2(degree_p + 1);
    localparam int unsigned IdxW  = (filter_els_p > 1) ? $clog2(filter_els_p) : 1;

    typedef enum logic [0:0] {e_idle, e_issue} state_e;

    state_e                   state_q, state_d;
    logic [vaddr_width_p-1:0] cand_q, cand_d;
    logic [vaddr_width_p-1:0] stride_q, stride_d;
    logic [PageW-1:0]         page_q, page_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [CntW-1:0]          target_q, target_d;
    logic                     pend_v_q, pend_v_d;
    logic [vaddr_width_p-1:0] pend_addr_q, pend_addr_d;
    logic [vaddr_width_p-1:0] pend_stride_q, pend_stride_d;
    logic                     pend_confirm_q, pend_confirm_d;
    logic [LineW-1:0]         filt_line_q [filter_els_p];
    logic [filter_els_p-1:0]  filt_v_q;
    logic [IdxW-1:0]          tail_q;

    logic                     trig, hit, in_page, issuing, handshake;
    logic                     load_new, load_pend, adv, ins;
    logic [vaddr_width_p-1:0] stride_ext, ld_addr, ld_stride;
    logic                     ld_confirm;
    logic [LineW-1:0]         cand_line;

    assign trig       = (start_discovery_i | confirm_discovery_i) && (stride_i != '0);
    assign stride_ext = {{(vaddr_width_p - stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
    assign cand_line  = cand_q[vaddr_width_p-1:block_offset_width_p];
    assign in_page    = (cand_q[vaddr_width_p-1:page_offset_width_p] == page_q);
    assign issuing    = (state_q == e_issue);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < filter_els_p; i++) begin
            if (filt_v_q[i] && (filt_line_q[i] == cand_line)) hit = 1'b1;
        end
    end

    assign pf_v_o    = issuing & in_page & ~hit;
    assign pf_addr_o = cand_q;
    assign busy_o    = issuing | pend_v_q;
    assign handshake = pf_v_o & pf_ready_and_i;

    always_comb begin
        state_d        = state_q;
        cand_d         = cand_q;
        stride_d       = stride_q;
        page_d         = page_q;
        cnt_d          = cnt_q;
        target_d       = target_q;
        pend_v_d       = pend_v_q;
        pend_addr_d    = pend_addr_q;
        pend_stride_d  = pend_stride_q;
        pend_confirm_d = pend_confirm_q;
        load_new       = 1'b0;
        load_pend      = 1'b0;
        adv            = 1'b0;
        ins            = 1'b0;

        unique case (state_q)
            e_idle: load_new = trig;
            e_issue: begin
                if (!pf_v_o) begin
                    // Nothing outstanding: a trigger can abort the stream right away.
                    if (trig)          load_new = 1'b1;
                    else if (!in_page) state_d  = e_idle;
                    else               adv      = 1'b1;
                end else if (pf_ready_and_i) begin
                    ins = 1'b1;
                    if (trig) begin
                        load_new = 1'b1;
                        pend_v_d = 1'b0;
                    end else if (pend_v_q) begin
                        load_pend = 1'b1;
                        pend_v_d  = 1'b0;
                    end else begin
                        adv = 1'b1;
                    end
                end else if (trig) begin
                    pend_v_d       = 1'b1;
                    pend_addr_d    = addr_i;
                    pend_stride_d  = stride_ext;
                    pend_confirm_d = confirm_discovery_i;
                end
            end
            default: state_d = e_idle;
        endcase

        ld_addr    = load_pend ? pend_addr_q : addr_i;
        ld_stride  = load_pend ? pend_stride_q : stride_ext;
        ld_confirm = load_pend ? pend_confirm_q : confirm_discovery_i;

        if (load_new || load_pend) begin
            state_d  = e_issue;
            cand_d   = ld_addr + ld_stride;
            stride_d = ld_stride;
            page_d   = ld_addr[vaddr_width_p-1:page_offset_width_p];
            cnt_d    = '0;
            target_d = ld_confirm ? CntW'(degree_p) : CntW'(1);
        end else if (adv) begin
            if (cnt_q + CntW'(1) == target_q) begin
                state_d = e_idle;
            end else begin
                cnt_d  = cnt_q + CntW'(1);
                cand_d = cand_q + stride_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= e_idle;
            cand_q         <= '0;
            stride_q       <= '0;
            page_q         <= '0;
            cnt_q          <= '0;
            target_q       <= '0;
            pend_v_q       <= 1'b0;
            pend_addr_q    <= '0;
            pend_stride_q  <= '0;
            pend_confirm_q <= 1'b0;
            filt_v_q       <= '0;
            tail_q         <= '0;
        end else begin
            state_q        <= state_d;
            cand_q         <= cand_d;
            stride_q       <= stride_d;
            page_q         <= page_d;
            cnt_q          <= cnt_d;
            target_q       <= target_d;
            pend_v_q       <= pend_v_d;
            pend_addr_q    <= pend_addr_d;
            pend_stride_q  <= pend_stride_d;
            pend_confirm_q <= pend_confirm_d;
            if (ins) begin
                filt_v_q[tail_q] <= 1'b1;
                tail_q <= (tail_q == IdxW'(filter_els_p - 1)) ? '0 : tail_q + IdxW'(1);
            end
        end
    end

    // Line tags need no reset; the valid bits gate every lookup.
    always_ff @(posedge clk_i) begin
        if (!reset_i && ins) filt_line_q[tail_q] <= cand_line;
    end

endmodule

// File: tb/tb_bp_be_prefetch_issuer.sv
// Bench for bp_be_prefetch_issuer: directed vector table followed by random stimulus checked
// against a queue-based stream model.
module tb_bp_be_prefetch_issuer;

    localparam int VW  = 39;
    localparam int LW  = VW - 6;
    localparam int DEG = 4;
    localparam int FEL = 8;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_discovery_i = 1'b0;
    logic          confirm_discovery_i = 1'b0;
    logic [VW-1:0] addr_i = '0;
    logic [7:0]    stride_i = '0;
    logic          pf_v_o;
    logic [VW-1:0] pf_addr_o;
    logic          pf_ready_and_i = 1'b0;
    logic          busy_o;

    bp_be_prefetch_issuer #(
        .vaddr_width_p       (VW),
        .stride_width_p      (8),
        .degree_p            (DEG),
        .filter_els_p        (FEL),
        .block_offset_width_p(6),
        .page_offset_width_p (12)
    ) dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .start_discovery_i  (start_discovery_i),
        .confirm_discovery_i(confirm_discovery_i),
        .addr_i             (addr_i),
        .stride_i           (stride_i),
        .pf_v_o             (pf_v_o),
        .pf_addr_o          (pf_addr_o),
        .pf_ready_and_i     (pf_ready_and_i),
        .busy_o             (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a stream is the precomputed list of its candidates; a page crossing
    // leaves a marker that costs one idle cycle.
    typedef struct { logic [VW-1:0] a; bit mark; } ent_t;
    ent_t          mq[$];
    logic [LW-1:0] mf[$];
    bit            m_act, m_pv, m_pc;
    logic [VW-1:0] m_pa;
    logic [7:0]    m_ps;

    function automatic void m_load(input logic [VW-1:0] b, input logic [7:0] s, input bit conf);
        logic signed [VW-1:0] se;
        logic [VW-1:0] c;
        int n;
        se = $signed(s);
        c = b;
        n = conf ? DEG : 1;
        mq.delete();
        for (int k = 1; k <= n; k++) begin
            c = c + se;
            if (c[VW-1:12] != b[VW-1:12]) begin
                mq.push_back('{c, 1'b1});
                break;
            end
            mq.push_back('{c, 1'b0});
        end
        m_act = 1'b1;
    endfunction

    function automatic bit m_hit(input logic [LW-1:0] l);
        foreach (mf[i]) if (mf[i] == l) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_v();
        if (!m_act) return 1'b0;
        if (mq[0].mark) return 1'b0;
        return !m_hit(mq[0].a[VW-1:6]);
    endfunction

    task automatic m_check();
        bit ev;
        ev = m_v();
        check("model_v", {38'b0, pf_v_o}, {38'b0, ev});
        check("model_busy", {38'b0, busy_o}, {38'b0, (m_act | m_pv)});
        if (ev) check("model_addr", pf_addr_o, mq[0].a);
    endtask

    function automatic void m_update(input bit rst, input bit st, input bit cf,
                                     input logic [VW-1:0] a, input logic [7:0] s, input bit rdy);
        bit trig, v;
        trig = (st | cf) && (s != 8'd0);
        v = m_v();
        if (rst) begin
            mq.delete();
            mf.delete();
            m_act = 1'b0;
            m_pv  = 1'b0;
        end else if (!m_act) begin
            if (trig) m_load(a, s, cf);
        end else if (!v) begin
            void'(mq.pop_front());
            if (trig) m_load(a, s, cf);
            else if (mq.size() == 0) m_act = 1'b0;
        end else if (rdy) begin
            if (mf.size() == FEL) void'(mf.pop_front());
            mf.push_back(mq[0].a[VW-1:6]);
            void'(mq.pop_front());
            if (trig) begin
                m_load(a, s, cf);
                m_pv = 1'b0;
            end else if (m_pv) begin
                m_load(m_pa, m_ps, m_pc);
                m_pv = 1'b0;
            end else if (mq.size() == 0) begin
                m_act = 1'b0;
            end
        end else if (trig) begin
            m_pv = 1'b1;
            m_pa = a;
            m_ps = s;
            m_pc = cf;
        end
    endfunction

    task automatic drive(input bit rst, input bit st, input bit cf, input logic [VW-1:0] a,
                         input logic [7:0] s, input bit rdy);
        reset_i             = rst;
        start_discovery_i   = st;
        confirm_discovery_i = cf;
        addr_i              = a;
        stride_i            = s;
        pf_ready_and_i      = rdy;
    endtask

    task automatic tick(input bit rst, input bit st, input bit cf, input logic [VW-1:0] a,
                        input logic [7:0] s, input bit rdy);
        m_update(rst, st, cf, a, s, rdy);
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        bit rst; bit st; bit cf; logic [VW-1:0] a; logic [7:0] s; bit rdy;
        bit ev; logic [VW-1:0] ea; bit eb;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input bit rst, input bit st, input bit cf, input int a,
                                input logic [7:0] s, input bit rdy, input bit ev, input int ea,
                                input bit eb);
        vec_t v;
        v.rst = rst; v.st = st; v.cf = cf; v.a = VW'(a); v.s = s; v.rdy = rdy;
        v.ev = ev; v.ea = VW'(ea); v.eb = eb;
        return v;
    endfunction

    initial begin
        // Expected outputs are those visible before the edge that samples the row's inputs.
        tbl.push_back(mk(0, 0, 1, 'h1000, 8'h40, 1, 0, 0,       0));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 1, 'h1040,  1));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 1, 'h1080,  1));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 1, 'h10C0,  1));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 1, 'h1100,  1));
        tbl.push_back(mk(0, 1, 0, 'h2000, 8'hF8, 1, 0, 0,       0));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 0, 0,       1));
        tbl.push_back(mk(0, 1, 0, 'h2100, 8'hF8, 1, 0, 0,       0));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 1, 'h20F8,  1));
        tbl.push_back(mk(0, 0, 1, 'h3000, 8'h10, 1, 0, 0,       0));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 1, 'h3010,  1));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 0, 0,       1));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 0, 0,       1));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 1, 'h3040,  1));
        tbl.push_back(mk(0, 0, 1, 'h1F00, 8'h40, 1, 0, 0,       0));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 1, 'h1F40,  1));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 1, 'h1F80,  1));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 1, 'h1FC0,  1));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 0, 0,       1));
        tbl.push_back(mk(0, 0, 1, 'h1000, 8'h40, 0, 0, 0,       0));
        tbl.push_back(mk(0, 0, 1, 'h5000, 8'h40, 0, 1, 'h1040,  1));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 0, 1, 'h1040,  1));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 1, 'h1040,  1));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 1, 'h5040,  1));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 1, 'h5080,  1));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 1, 'h50C0,  1));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 1, 'h5100,  1));
        tbl.push_back(mk(0, 0, 1, 'h6000, 8'h40, 0, 0, 0,       0));
        tbl.push_back(mk(1, 0, 0, 0,      8'h00, 0, 1, 'h6040,  1));
        tbl.push_back(mk(0, 1, 0, 'h5000, 8'h40, 1, 0, 0,       0));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 1, 'h5040,  1));
        tbl.push_back(mk(0, 0, 0, 0,      8'h00, 1, 0, 0,       0));

        drive(1, 0, 0, '0, 8'h00, 0);
        tick(1, 0, 0, '0, 8'h00, 0);
        tick(1, 0, 0, '0, 8'h00, 0);
        drive(0, 0, 0, '0, 8'h00, 0);
        check("reset_v", {38'b0, pf_v_o}, '0);
        check("reset_addr", pf_addr_o, '0);
        check("reset_busy", {38'b0, busy_o}, '0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].st, tbl[i].cf, tbl[i].a, tbl[i].s, tbl[i].rdy);
            #1;
            check($sformatf("vec%0d_v", i), {38'b0, pf_v_o}, {38'b0, tbl[i].ev});
            check($sformatf("vec%0d_busy", i), {38'b0, busy_o}, {38'b0, tbl[i].eb});
            if (tbl[i].ev) check($sformatf("vec%0d_addr", i), pf_addr_o, tbl[i].ea);
            m_check();
            tick(tbl[i].rst, tbl[i].st, tbl[i].cf, tbl[i].a, tbl[i].s, tbl[i].rdy);
        end

        for (int n = 0; n < 4000; n++) begin
            bit rst, st, cf, rdy;
            logic [VW-1:0] a;
            logic [7:0] s;
            rst = ($urandom_range(0, 499) == 0);
            st  = ($urandom_range(0, 7) == 0);
            cf  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            a   = VW'($urandom_range(0, 3) * 4096 + $urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1) begin
                s = 8'($urandom_range(0, 40));
                if ($urandom_range(0, 1) == 1) s = -s;
            end else begin
                s = 8'($urandom);
            end
            drive(rst, st, cf, a, s, rdy);
            #1;
            m_check();
            tick(rst, st, cf, a, s, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
